// File: rtl/coin_block_trigger.sv
// Question-block head-bump detector: scans a fixed block table once per upward frame,
// launches the coin animator on a hit, and tracks used blocks plus the coin tally.
module coin_block_trigger #(
  parameter int NUM_BLOCKS     = 8,
  parameter int BLOCK_SIZE     = 16,
  parameter int MARIO_W        = 16,
  parameter int POP_HEIGHT     = 32,
  parameter int TIMEOUT_FRAMES = 128
) (
  input  logic                  clk_pixel,
  input  logic                  sys_rst_n,
  input  logic                  new_frame,
  input  logic [12:0]           mario_x,
  input  logic [9:0]            mario_y,
  input  logic                  mario_up,
  input  logic                  level_reset,
  input  logic                  coin_up,
  input  logic [9:0]            coin_y,
  output logic                  coin_effect,
  output logic                  coin_rst,
  output logic [12:0]           x_start,
  output logic [9:0]            y_start,
  output logic [9:0]            y_end,
  output logic [NUM_BLOCKS-1:0] block_used,
  output logic [6:0]            coin_count,
  output logic                  coin_collected,
  output logic                  extra_life
);

  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    LOAD   = 3'd2,
    ACTIVE = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [TW-1:0]   timer_r;

  logic [12:0]     bx_s;
  logic [9:0]      by_s;
  logic [13:0]     mx_s;
  logic [13:0]     my_s;
  logic [13:0]     bx14_s;
  logic [13:0]     by14_s;
  logic            hit_s;
  logic            done_s;

  function automatic logic [12:0] blk_x(input logic [IW-1:0] i);
    logic [12:0] v;
    case (i)
      IW'(0):  v = 13'd384;
      IW'(1):  v = 13'd352;
      IW'(2):  v = 13'd1248;
      IW'(3):  v = 13'd1504;
      IW'(4):  v = 13'd1504;
      IW'(5):  v = 13'd1616;
      IW'(6):  v = 13'd1744;
      IW'(7):  v = 13'd1872;
      default: v = 13'd0;
    endcase
    return v;
  endfunction

  function automatic logic [9:0] blk_y(input logic [IW-1:0] i);
    logic [9:0] v;
    case (i)
      IW'(0):  v = 10'd160;
      IW'(1):  v = 10'd96;
      IW'(2):  v = 10'd160;
      IW'(3):  v = 10'd160;
      IW'(4):  v = 10'd96;
      IW'(5):  v = 10'd160;
      IW'(6):  v = 10'd96;
      IW'(7):  v = 10'd160;
      default: v = 10'd0;
    endcase
    return v;
  endfunction

  // Hit test for the block under the scan index; widened to 14 bits so sums never wrap.
  always_comb begin
    bx_s   = blk_x(idx_r);
    by_s   = blk_y(idx_r);
    mx_s   = {1'b0, mario_x};
    my_s   = {4'b0000, mario_y};
    bx14_s = {1'b0, bx_s};
    by14_s = {4'b0000, by_s};
    hit_s  = (mx_s + 14'(MARIO_W) > bx14_s)
          && (mx_s < bx14_s + 14'(BLOCK_SIZE))
          && (my_s >= by14_s)
          && (my_s < by14_s + 14'(BLOCK_SIZE))
          && !block_used[idx_r];
  end

  // End of effect: coin back at its start height on the way up, or the frame timeout.
  always_comb begin
    done_s = (coin_up && (coin_y == y_start)) || (timer_r == TW'(TIMEOUT_FRAMES));
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r        <= IDLE;
      idx_r          <= '0;
      timer_r        <= '0;
      coin_effect    <= 1'b0;
      coin_rst       <= 1'b0;
      x_start        <= 13'd0;
      y_start        <= 10'd0;
      y_end          <= 10'd0;
      block_used     <= '0;
      coin_count     <= 7'd0;
      coin_collected <= 1'b0;
      extra_life     <= 1'b0;
    end else begin
      coin_rst       <= 1'b0;
      coin_collected <= 1'b0;
      extra_life     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (new_frame && mario_up) begin
            state_r <= SCAN;
            idx_r   <= '0;
          end
        end
        SCAN: begin
          if (hit_s) begin
            x_start  <= bx_s;
            y_start  <= by_s - 10'(BLOCK_SIZE);
            y_end    <= by_s - 10'(BLOCK_SIZE) - 10'(POP_HEIGHT);
            coin_rst <= 1'b1;
            state_r  <= LOAD;
          end else if (idx_r == IW'(NUM_BLOCKS - 1)) begin
            state_r <= IDLE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        LOAD: begin
          timer_r     <= '0;
          coin_effect <= 1'b1;
          state_r     <= ACTIVE;
        end
        ACTIVE: begin
          if (done_s) begin
            coin_effect    <= 1'b0;
            coin_collected <= 1'b1;
            if (coin_count == 7'd99) begin
              coin_count <= 7'd0;
              extra_life <= 1'b1;
            end else begin
              coin_count <= coin_count + 7'd1;
            end
            state_r <= FINISH;
          end else if (new_frame) begin
            timer_r <= timer_r + TW'(1);
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          coin_effect <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
      // A level clear overrides the bit LOAD would set in the same cycle.
      if (level_reset) begin
        block_used <= '0;
      end else if (state_r == LOAD) begin
        block_used[idx_r] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coin_block_trigger.sv
// Self-checking bench for coin_block_trigger: directed bumps plus random positions
// checked against a table-driven reference model of hits, used blocks and coin tally.
module tb_coin_block_trigger;

  localparam int NB      = 8;
  localparam int TIMEOUT = 128;

  logic        clk_pixel = 1'b0;
  logic        sys_rst_n;
  logic        new_frame;
  logic [12:0] mario_x;
  logic [9:0]  mario_y;
  logic        mario_up;
  logic        level_reset;
  logic        coin_up;
  logic [9:0]  coin_y;
  logic        coin_effect;
  logic        coin_rst;
  logic [12:0] x_start;
  logic [9:0]  y_start;
  logic [9:0]  y_end;
  logic [7:0]  block_used;
  logic [6:0]  coin_count;
  logic        coin_collected;
  logic        extra_life;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          bx_tab [8] = '{384, 352, 1248, 1504, 1504, 1616, 1744, 1872};
  int          by_tab [8] = '{160, 96, 160, 160, 96, 160, 96, 160};
  logic [7:0]  used_m  = 8'h00;
  int          count_m = 0;
  logic [12:0] ex_x    = 13'd0;
  logic [9:0]  ex_ys   = 10'd0;
  logic [9:0]  ex_ye   = 10'd0;

  coin_block_trigger dut (
    .clk_pixel      (clk_pixel),
    .sys_rst_n      (sys_rst_n),
    .new_frame      (new_frame),
    .mario_x        (mario_x),
    .mario_y        (mario_y),
    .mario_up       (mario_up),
    .level_reset    (level_reset),
    .coin_up        (coin_up),
    .coin_y         (coin_y),
    .coin_effect    (coin_effect),
    .coin_rst       (coin_rst),
    .x_start        (x_start),
    .y_start        (y_start),
    .y_end          (y_end),
    .block_used     (block_used),
    .coin_count     (coin_count),
    .coin_collected (coin_collected),
    .extra_life     (extra_life)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First unused block whose box Mario's head bumps, or -1.
  function automatic int model_hit(input int mx, input int my, input logic [7:0] used);
    for (int i = 0; i < NB; i++) begin
      if (!used[i] && (mx + 16 > bx_tab[i]) && (mx < bx_tab[i] + 16) &&
          (my >= by_tab[i]) && (my < by_tab[i] + 16))
        return i;
    end
    return -1;
  endfunction

  task automatic lvl_reset();
    level_reset = 1'b1;
    @(negedge clk_pixel);
    level_reset = 1'b0;
    used_m = 8'h00;
    chk("level_reset_clear", block_used, used_m);
  endtask

  task automatic bump(input int mx, input int my, input bit up, input bit clr_at_load,
                      output int hit);
    mario_x   = 13'(mx);
    mario_y   = 10'(my);
    mario_up  = up;
    new_frame = 1'b1;
    hit = up ? model_hit(mx, my, used_m) : -1;
    @(negedge clk_pixel);
    new_frame = 1'b0;
    if (hit < 0) begin
      for (int k = 0; k < NB + 2; k++) begin
        chk("no_hit_quiet", {coin_rst, coin_effect, x_start, y_start, y_end, block_used},
            {2'b00, ex_x, ex_ys, ex_ye, used_m});
        @(negedge clk_pixel);
      end
    end else begin
      for (int k = 0; k <= hit; k++) begin
        chk("scan_no_rst", {coin_rst, coin_effect}, 2'b00);
        @(negedge clk_pixel);
      end
      ex_x  = 13'(bx_tab[hit]);
      ex_ys = 10'(by_tab[hit] - 16);
      ex_ye = 10'(by_tab[hit] - 16 - 32);
      chk("load_coords", {coin_rst, coin_effect, x_start, y_start, y_end},
          {2'b10, ex_x, ex_ys, ex_ye});
      if (clr_at_load) level_reset = 1'b1;
      @(negedge clk_pixel);
      level_reset = 1'b0;
      if (clr_at_load) used_m = 8'h00;
      else used_m[hit] = 1'b1;
      chk("active_start", {coin_rst, coin_effect, block_used}, {2'b01, used_m});
    end
  endtask

  task automatic finish_coin();
    bit wrap;
    coin_up = 1'b1;
    coin_y  = ex_ys + 10'd1;
    @(negedge clk_pixel);
    chk("wrong_y_no_finish", {coin_effect, coin_collected}, 2'b10);
    coin_up = 1'b0;
    coin_y  = ex_ys;
    @(negedge clk_pixel);
    chk("falling_no_finish", {coin_effect, coin_collected}, 2'b10);
    coin_up = 1'b1;
    @(negedge clk_pixel);
    coin_up = 1'b0;
    wrap = (count_m == 99);
    count_m = wrap ? 0 : count_m + 1;
    chk("finish_pulse", {coin_effect, coin_collected, extra_life, coin_count},
        {1'b0, 1'b1, wrap, 7'(count_m)});
    @(negedge clk_pixel);
    chk("after_finish", {coin_effect, coin_collected, extra_life, coin_count},
        {3'b000, 7'(count_m)});
  endtask

  initial begin
    int h;
    sys_rst_n   = 1'b0;
    new_frame   = 1'b0;
    mario_x     = 13'd0;
    mario_y     = 10'd0;
    mario_up    = 1'b0;
    level_reset = 1'b0;
    coin_up     = 1'b0;
    coin_y      = 10'd0;
    #12;
    chk("reset_state", {coin_effect, coin_rst, x_start, y_start, y_end, block_used, coin_count,
        coin_collected, extra_life}, 64'd0);
    @(negedge clk_pixel);
    sys_rst_n = 1'b1;
    @(negedge clk_pixel);

    // Block 0 bump, finish, then the same bump must not reload
    bump(380, 170, 1'b1, 1'b0, h);
    chk("block0_index", 64'(h), 64'd0);
    chk("block0_used", block_used, 8'h01);
    finish_coin();
    bump(380, 170, 1'b1, 1'b0, h);

    // Stacked blocks: only block 4 hits; level_reset mid-effect keeps the coin going
    lvl_reset();
    bump(1500, 100, 1'b1, 1'b0, h);
    chk("stacked_used", block_used, 8'h10);
    lvl_reset();
    chk("lr_keeps_effect", coin_effect, 1'b1);
    finish_coin();

    // mario_up low, and an empty-air scan
    bump(1500, 100, 1'b0, 1'b0, h);
    bump(0, 170, 1'b1, 1'b0, h);

    // Clear arriving in the LOAD cycle wins over the new used bit
    bump(350, 100, 1'b1, 1'b1, h);
    finish_coin();

    for (int r = 0; r < 40; r++) begin
      int ti, mx, my;
      bit up;
      if ($urandom_range(0, 3) == 0) lvl_reset();
      ti = int'($urandom_range(0, 7));
      mx = bx_tab[ti] + int'($urandom_range(0, 33)) - 17;
      my = by_tab[ti] + int'($urandom_range(0, 19)) - 2;
      up = ($urandom_range(0, 4) != 0);
      bump(mx, my, up, 1'b0, h);
      if (h >= 0) finish_coin();
    end

    // Timeout; frames during ACTIVE over block 2 must not use it
    lvl_reset();
    bump(380, 170, 1'b1, 1'b0, h);
    mario_x  = 13'd1250;
    mario_y  = 10'd165;
    mario_up = 1'b1;
    for (int p = 1; p < TIMEOUT; p++) begin
      new_frame = 1'b1;
      @(negedge clk_pixel);
      new_frame = 1'b0;
      @(negedge clk_pixel);
    end
    chk("timeout_127_hold", {coin_effect, coin_collected}, 2'b10);
    new_frame = 1'b1;
    @(negedge clk_pixel);
    new_frame = 1'b0;
    chk("timeout_128_active", {coin_effect, coin_collected}, 2'b10);
    @(negedge clk_pixel);
    mario_up = 1'b0;
    count_m = (count_m == 99) ? 0 : count_m + 1;
    chk("timeout_finish", {coin_effect, coin_collected, coin_count, block_used},
        {2'b01, 7'(count_m), used_m});
    @(negedge clk_pixel);
    chk("timeout_idle", {coin_effect, coin_collected, coin_rst}, 3'b000);

    // Run the tally up to 99, then wrap
    while (count_m != 99) begin
      lvl_reset();
      bump(380, 170, 1'b1, 1'b0, h);
      finish_coin();
    end
    lvl_reset();
    bump(380, 170, 1'b1, 1'b0, h);
    finish_coin();
    chk("wrap_count_zero", coin_count, 7'd0);

    // Asynchronous reset in the middle of an effect
    lvl_reset();
    bump(380, 170, 1'b1, 1'b0, h);
    @(negedge clk_pixel);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_reset", {coin_effect, block_used, coin_count}, 64'd0);
    @(negedge clk_pixel);
    sys_rst_n = 1'b1;
    used_m  = 8'h00;
    count_m = 0;
    ex_x    = 13'd0;
    ex_ys   = 10'd0;
    ex_ye   = 10'd0;
    chk("after_async_reset", {coin_effect, coin_rst, x_start, y_start, y_end, block_used,
        coin_count, coin_collected, extra_life}, 64'd0);
    @(negedge clk_pixel);
    bump(380, 170, 1'b1, 1'b0, h);
    finish_coin();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_block_trigger.md
# coin_block_trigger

Upstream stage of the coin pop-up animation. It watches Mario's world position once per frame and detects a head-bump from below against a fixed table of question blocks. On a hit it loads the coin animator with start/end coordinates, restarts it, and holds `coin_effect` high until the animation returns to its start height. It also records used blocks for the renderer and keeps the coin tally.

## Interface
Parameters:
- `NUM_BLOCKS`, 8: entries in block table (table fixed in RTL, see Operation).
- `BLOCK_SIZE`, 16: block edge in pixels.
- `MARIO_W`, 16: Mario hitbox width in pixels.
- `POP_HEIGHT`, 32: coin rise height in pixels.
- `TIMEOUT_FRAMES`, 128: ACTIVE safety timeout, in frames.

Ports:
- `clk_pixel` in 1: pixel clock, single clock domain.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low.
- `new_frame` in 1: one-cycle pulse per frame.
- `mario_x` in 13: Mario hitbox left edge, world coordinates.
- `mario_y` in 10: Mario hitbox top edge.
- `mario_up` in 1: Mario vertical velocity is upward.
- `level_reset` in 1: clears `block_used`; `coin_count` is kept.
- `coin_up` in 1: animator's `up` flag.
- `coin_y` in 10: animator's current y.
- `coin_effect` out 1: enables the animator.
- `coin_rst` out 1: active-high restart pulse to the animator's reset.
- `x_start` out 13, `y_start` out 10, `y_end` out 10: animator coordinates.
- `block_used` out NUM_BLOCKS: bit i set means block i has already been emptied.
- `coin_count` out 7: 0..99.
- `coin_collected` out 1: one-cycle pulse per finished coin.
- `extra_life` out 1: one-cycle pulse when the count wraps from 99 to 0.

## Operation
- Block table, entries (bx, by) are top-left corners, index 0..7: (384,160), (352,96), (1248,160), (1504,160), (1504,96), (1616,160), (1744,96), (1872,160).
- Hit test for block i:
  - Horizontal overlap: `mario_x + MARIO_W > bx` and `mario_x < bx + BLOCK_SIZE`.
  - Vertical: `by <= mario_y < by + BLOCK_SIZE`.
  - Block not already used: `!block_used[i]`.
  - Compare in 14 bits so the additions cannot overflow.
- FSM states: IDLE, SCAN, LOAD, ACTIVE, FINISH.
  - IDLE: if `new_frame && mario_up`, go to SCAN with idx=0. Otherwise stay.
  - SCAN: test one block per cycle, starting at idx. On a hit, latch idx and go to LOAD. If idx == NUM_BLOCKS-1 with no hit, go to IDLE. Otherwise idx+1. The lowest index wins. `mario_*` is sampled live during the scan.
  - SCAN→LOAD transition: register `x_start=bx`, `y_start=by-BLOCK_SIZE`, `y_end=y_start-POP_HEIGHT`.
  - LOAD: one cycle. `coin_rst=1`, set `block_used[idx]`, clear the frame timer, then go to ACTIVE.
  - ACTIVE: `coin_effect=1`. Increment the frame timer on `new_frame`. Go to FINISH when `coin_up && coin_y == y_start`, or when the timer reaches TIMEOUT_FRAMES.
  - FINISH: one cycle. `coin_effect=0`, pulse `coin_collected`, increment `coin_count`. At 99 the count wraps to 0 and `extra_life` pulses. Then go to IDLE.
- Hits are ignored outside IDLE. A bump during ACTIVE leaves the block unused.
- `level_reset`:
  - Clears `block_used` in any state.
  - If LOAD sets a bit in the same cycle, the clear wins.
  - It does not abort an active effect.
- `x_start`/`y_start`/`y_end` hold their last value until the next LOAD.

## Timing
- Reset (async, while `sys_rst_n=0`): state IDLE, all outputs 0 (`coin_effect`, `coin_rst`, coordinates, `block_used`, `coin_count`, pulses). Leaves reset on the first `clk_pixel` edge after release.
- All outputs are registered.
- Latency, with `new_frame` sampled at edge T and block i the first hit:
  - SCAN occupies T+1..T+1+i.
  - LOAD occurs at T+2+i: `coin_rst` high for that cycle, coordinates valid from that cycle.
  - `coin_effect` rises at T+3+i.
  - No-hit scan returns to IDLE after NUM_BLOCKS cycles.
- End of effect: the qualifying `coin_up`/`coin_y` is seen at edge E. FINISH is E+1, when `coin_effect` falls and `coin_collected`/`extra_life` pulse. IDLE is E+2.
- A `new_frame` arriving during SCAN/LOAD/ACTIVE/FINISH is dropped. The next detection needs a later `new_frame`.
- Reset asserted mid-effect: `coin_effect` drops asynchronously and `block_used` clears.

## Test plan
- Hit on block 0: `mario_x=380`, `mario_y=170`, `mario_up=1`, `new_frame` pulse → SCAN, LOAD, then ACTIVE. At LOAD, `x_start=384`, `y_start=144`, `y_end=112`, `coin_rst` high 1 cycle. `block_used=8'h01`. `coin_effect` high at T+3.
- Finish: after the above, drive `coin_up=1`, `coin_y=144` → `coin_effect` low next cycle, `coin_collected` one pulse, `coin_count=1`. Repeating the same bump gives no LOAD.
- Stacked blocks: `mario_x=1500`, `mario_y=100` → only block 4 hits: `y_start=80`, `y_end=48`, `block_used=8'h10`, `coin_effect` at T+7.
- No hit / `mario_up=0`: the same positions with `mario_up=0` give no SCAN. With `mario_x=0` and `mario_up=1`, the FSM returns to IDLE after 8 cycles and all outputs are unchanged.
- Timeout and wrap:
  - Hold `coin_up=0` in ACTIVE → FINISH after 128 `new_frame` pulses.
  - Use `level_reset` to reuse blocks and reach 99 coins. The next finish gives `coin_count=0` plus one `extra_life` pulse.
- Async reset in ACTIVE: drive `sys_rst_n=0` mid-cycle → `coin_effect=0` and `block_used=0` immediately, `coin_count=0`.
